// File: rtl/data_mem_responder.sv
`timescale 1ns/1ps
// data_mem_responder
// Word-organised data RAM behind the execute stage's memory request outputs.
// Stores are byte-masked and land in four byte-lane RAMs. Loads read one word,
// right-justify it by the byte offset, and return it after READ_LATENCY cycles
// through a valid/data/error shift pipeline. Error flags and wrapping request
// counters are provided for debug.
module data_mem_responder #(
    parameter int          DEPTH_WORDS  = 1024,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
    parameter int          READ_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_write_in,
    input  logic [31:0] mem_write_addr_in,
    input  logic [31:0] mem_write_data_in,
    input  logic [7:0]  mem_write_mask_in,
    input  logic        mem_read_in,
    input  logic [31:0] mem_read_addr_in,
    output logic [31:0] read_data_out,
    output logic        read_valid_out,
    output logic        read_error_out,
    output logic        write_error_out,
    output logic        busy_out,
    output logic [15:0] wr_count_out,
    output logic [15:0] rd_count_out
);

    localparam int AW = $clog2(DEPTH_WORDS);

    // ------------------------------------------------------------------
    // Address decode. Offsets are taken modulo 2^32, so an address below
    // BASE_ADDR wraps to a huge word index and fails the range check.
    // ------------------------------------------------------------------
    logic [31:0] wr_off;
    logic [31:0] rd_off;
    logic        wr_in_range;
    logic        rd_in_range;
    logic [AW-1:0] wr_word;
    logic [AW-1:0] rd_word;

    assign wr_off      = mem_write_addr_in - BASE_ADDR;
    assign rd_off      = mem_read_addr_in  - BASE_ADDR;
    assign wr_in_range = (wr_off[31:2] < 30'(DEPTH_WORDS));
    assign rd_in_range = (rd_off[31:2] < 30'(DEPTH_WORDS));
    assign wr_word     = wr_off[AW+1:2];
    assign rd_word     = rd_off[AW+1:2];

    // ------------------------------------------------------------------
    // Store lane steering. The mask is shifted in 8 bits so that any lane
    // pushed past byte 3 shows up in smask[7:4] and flags a straddling store.
    // ------------------------------------------------------------------
    logic [7:0]  wr_smask;
    logic [31:0] wr_bytes;
    logic        wr_err;
    logic        wr_ok;
    logic [3:0]  lane_we;

    assign wr_smask = {4'b0000, mem_write_mask_in[3:0]} << wr_off[1:0];
    assign wr_bytes = mem_write_data_in << {wr_off[1:0], 3'b000};
    assign wr_err   = (|wr_smask[7:4]) || !wr_in_range;
    assign wr_ok    = mem_write_in && !wr_err && !reset;
    assign lane_we  = wr_ok ? wr_smask[3:0] : 4'b0000;

    // Mask bits 7:4 carry no meaning here; the low offset bits of the
    // 32-bit offsets above the RAM index are covered by the range check.
    logic unused_bits;
    assign unused_bits = ^{mem_write_mask_in[7:4]};

    // ------------------------------------------------------------------
    // Byte-lane RAMs. Each lane is a plain array with a registered read so
    // it maps onto block RAM; the read samples the old contents on a
    // same-edge store to the same word (read-before-write).
    // ------------------------------------------------------------------
    logic [31:0] ram_word;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH_WORDS];
            logic [7:0] lane_q_reg;

            // Byte-lane write and registered read for lane gi.
            always_ff @(posedge clk) begin
                if (lane_we[gi]) begin
                    lane_mem[wr_word] <= wr_bytes[8*gi +: 8];
                end
                if (mem_read_in) begin
                    lane_q_reg <= lane_mem[rd_word];
                end
            end

            assign ram_word[8*gi +: 8] = lane_q_reg;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Response stage 1. The RAM output register holds the raw word; stage 1
    // qualifies it and right-justifies it by the remembered byte offset.
    // Data is forced to zero when the stage is empty or the load erred, so
    // reset alone is enough to clear the visible data.
    // ------------------------------------------------------------------
    logic        s1_valid_reg;
    logic        s1_err_reg;
    logic [1:0]  s1_byte_reg;
    logic [31:0] s1_data;

    // Capture the qualifiers of a load at its accept edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_reg <= 1'b0;
            s1_err_reg   <= 1'b0;
            s1_byte_reg  <= 2'b00;
        end else begin
            s1_valid_reg <= mem_read_in;
            s1_err_reg   <= mem_read_in && !rd_in_range;
            s1_byte_reg  <= rd_off[1:0];
        end
    end

    assign s1_data = (s1_valid_reg && !s1_err_reg)
                   ? (ram_word >> {s1_byte_reg, 3'b000})
                   : 32'h0000_0000;

    // ------------------------------------------------------------------
    // Remaining response stages 2..READ_LATENCY.
    // ------------------------------------------------------------------
    generate
        if (READ_LATENCY == 1) begin : g_lat1
            assign read_valid_out = s1_valid_reg;
            assign read_error_out = s1_err_reg;
            assign read_data_out  = s1_data;
            assign busy_out       = 1'b0;
        end else begin : g_latn
            logic [READ_LATENCY:2] pv_reg;
            logic [READ_LATENCY:2] pe_reg;
            logic [31:0]           pd_reg [2:READ_LATENCY];
            logic [READ_LATENCY:1] all_valid;

            // Shift responses one stage per cycle; reset drops in-flight loads.
            always_ff @(posedge clk) begin
                if (reset) begin
                    pv_reg <= '0;
                    pe_reg <= '0;
                    for (int k = 2; k <= READ_LATENCY; k++) begin
                        pd_reg[k] <= 32'h0000_0000;
                    end
                end else begin
                    pv_reg[2] <= s1_valid_reg;
                    pe_reg[2] <= s1_valid_reg && s1_err_reg;
                    pd_reg[2] <= s1_data;
                    for (int k = 3; k <= READ_LATENCY; k++) begin
                        pv_reg[k] <= pv_reg[k-1];
                        pe_reg[k] <= pe_reg[k-1];
                        pd_reg[k] <= pd_reg[k-1];
                    end
                end
            end

            assign all_valid      = {pv_reg, s1_valid_reg};
            assign busy_out       = |all_valid[READ_LATENCY-1:1];
            assign read_valid_out = pv_reg[READ_LATENCY];
            assign read_error_out = pe_reg[READ_LATENCY];
            assign read_data_out  = pd_reg[READ_LATENCY];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Store error flag and debug counters.
    // ------------------------------------------------------------------
    logic        write_error_reg;
    logic [15:0] wr_count_reg;
    logic [15:0] rd_count_reg;

    // Flag dropped stores for one cycle and count accepted requests.
    always_ff @(posedge clk) begin
        if (reset) begin
            write_error_reg <= 1'b0;
            wr_count_reg    <= 16'h0000;
            rd_count_reg    <= 16'h0000;
        end else begin
            write_error_reg <= mem_write_in && wr_err;
            if (mem_write_in && !wr_err) begin
                wr_count_reg <= wr_count_reg + 16'h0001;
            end
            if (mem_read_in) begin
                rd_count_reg <= rd_count_reg + 16'h0001;
            end
        end
    end

    assign write_error_out = write_error_reg;
    assign wr_count_out    = wr_count_reg;
    assign rd_count_out    = rd_count_reg;

endmodule

// File: tb/tb_data_mem_responder.sv
`timescale 1ns/1ps
// Directed bench for data_mem_responder: 16-word RAM, three-cycle load latency.
module tb_data_mem_responder;

    logic        clk;
    logic        reset;
    logic        mem_write_in;
    logic [31:0] mem_write_addr_in;
    logic [31:0] mem_write_data_in;
    logic [7:0]  mem_write_mask_in;
    logic        mem_read_in;
    logic [31:0] mem_read_addr_in;
    logic [31:0] read_data_out;
    logic        read_valid_out;
    logic        read_error_out;
    logic        write_error_out;
    logic        busy_out;
    logic [15:0] wr_count_out;
    logic [15:0] rd_count_out;

    int checks = 0;
    int fails  = 0;

    logic [31:0] stream_addr [4] = '{32'h10, 32'h13, 32'h0C, 32'h20};
    logic [31:0] stream_exp  [4] = '{32'h55AD1234, 32'h00000055, 32'h11223344, 32'h00000002};

    data_mem_responder #(
        .DEPTH_WORDS (16),
        .BASE_ADDR   (32'h0000_0000),
        .READ_LATENCY(3)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .mem_write_in     (mem_write_in),
        .mem_write_addr_in(mem_write_addr_in),
        .mem_write_data_in(mem_write_data_in),
        .mem_write_mask_in(mem_write_mask_in),
        .mem_read_in      (mem_read_in),
        .mem_read_addr_in (mem_read_addr_in),
        .read_data_out    (read_data_out),
        .read_valid_out   (read_valid_out),
        .read_error_out   (read_error_out),
        .write_error_out  (write_error_out),
        .busy_out         (busy_out),
        .wr_count_out     (wr_count_out),
        .rd_count_out     (rd_count_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit so the run always ends.
    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed no finish, required finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic store(input logic [31:0] addr, input logic [31:0] data, input logic [7:0] mask);
        mem_write_in      = 1'b1;
        mem_write_addr_in = addr;
        mem_write_data_in = data;
        mem_write_mask_in = mask;
        tick();
        mem_write_in      = 1'b0;
        $display("store addr=0x%08h data=0x%08h mask=0x%02h wr_err=%0b wr_count=%0d",
                 addr, data, mask, write_error_out, wr_count_out);
    endtask

    // Full load transaction: accept, two in-flight cycles, response, idle.
    task automatic load_chk(input string tag, input logic [31:0] addr,
                            input logic [31:0] exp_data, input logic exp_err);
        mem_read_in      = 1'b1;
        mem_read_addr_in = addr;
        tick();
        mem_read_in      = 1'b0;
        chk({tag, "_busy1"},  32'(busy_out), 32'd1);
        chk({tag, "_valid1"}, 32'(read_valid_out), 32'd0);
        tick();
        chk({tag, "_busy2"},  32'(busy_out), 32'd1);
        chk({tag, "_valid2"}, 32'(read_valid_out), 32'd0);
        tick();
        chk({tag, "_valid3"}, 32'(read_valid_out), 32'd1);
        chk({tag, "_data"},   read_data_out, exp_data);
        chk({tag, "_err"},    32'(read_error_out), 32'(exp_err));
        chk({tag, "_busy3"},  32'(busy_out), 32'd0);
        $display("load  addr=0x%08h data=0x%08h err=%0b", addr, read_data_out, read_error_out);
        tick();
        chk({tag, "_valid4"}, 32'(read_valid_out), 32'd0);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_data"},  read_data_out, 32'h0);
        chk({tag, "_valid"}, 32'(read_valid_out), 32'd0);
        chk({tag, "_rerr"},  32'(read_error_out), 32'd0);
        chk({tag, "_werr"},  32'(write_error_out), 32'd0);
        chk({tag, "_busy"},  32'(busy_out), 32'd0);
        chk({tag, "_wrcnt"}, 32'(wr_count_out), 32'd0);
        chk({tag, "_rdcnt"}, 32'(rd_count_out), 32'd0);
    endtask

    initial begin
        reset             = 1'b1;
        mem_write_in      = 1'b0;
        mem_write_addr_in = 32'h0;
        mem_write_data_in = 32'h0;
        mem_write_mask_in = 8'h0;
        mem_read_in       = 1'b0;
        mem_read_addr_in  = 32'h0;

        // Reset state, during reset and in the first cycle after release.
        tick();
        tick();
        chk_idle("rst_hold");
        reset = 1'b0;
        tick();
        chk_idle("rst_after");

        // Word round-trip.
        store(32'h10, 32'hDEADBEEF, 8'h0F);
        chk("word_wrcnt", 32'(wr_count_out), 32'd1);
        chk("word_werr",  32'(write_error_out), 32'd0);
        load_chk("word", 32'h10, 32'hDEADBEEF, 1'b0);
        chk("word_rdcnt", 32'(rd_count_out), 32'd1);

        // Byte and half stores; upper mask bits are ignored.
        store(32'h13, 32'h00000055, 8'hF1);
        store(32'h10, 32'h00001234, 8'h03);
        load_chk("merge", 32'h10, 32'h55AD1234, 1'b0);
        load_chk("byte3", 32'h13, 32'h00000055, 1'b0);
        load_chk("byte1", 32'h11, 32'h0055AD12, 1'b0);
        chk("merge_wrcnt", 32'(wr_count_out), 32'd3);

        // Errors: straddling half store, out-of-range store and load.
        store(32'h0C, 32'h11223344, 8'h0F);
        store(32'h0F, 32'h0000AAAA, 8'h03);
        chk("strad_werr", 32'(write_error_out), 32'd1);
        tick();
        chk("strad_werr_clr", 32'(write_error_out), 32'd0);
        store(32'h40, 32'hCAFEF00D, 8'h0F);
        chk("oor_werr", 32'(write_error_out), 32'd1);
        load_chk("strad_keep", 32'h0C, 32'h11223344, 1'b0);
        load_chk("oor_load", 32'h40, 32'h00000000, 1'b1);
        chk("err_wrcnt", 32'(wr_count_out), 32'd4);
        chk("err_rdcnt", 32'(rd_count_out), 32'd6);

        // Same-edge load and store to one word: load sees old data.
        store(32'h20, 32'h00000001, 8'h0F);
        mem_write_in      = 1'b1;
        mem_write_addr_in = 32'h20;
        mem_write_data_in = 32'h00000002;
        mem_write_mask_in = 8'h0F;
        mem_read_in       = 1'b1;
        mem_read_addr_in  = 32'h20;
        tick();
        mem_write_in = 1'b0;
        mem_read_in  = 1'b0;
        tick();
        tick();
        chk("hazard_valid", 32'(read_valid_out), 32'd1);
        chk("hazard_old",   read_data_out, 32'h00000001);
        $display("load  addr=0x00000020 data=0x%08h err=%0b (same-edge store)", read_data_out, read_error_out);
        tick();
        load_chk("hazard_new", 32'h20, 32'h00000002, 1'b0);
        chk("hazard_wrcnt", 32'(wr_count_out), 32'd6);
        chk("hazard_rdcnt", 32'(rd_count_out), 32'd8);

        // Streaming: four back-to-back loads, four back-to-back responses.
        for (int i = 0; i < 6; i++) begin
            if (i < 4) begin
                mem_read_in      = 1'b1;
                mem_read_addr_in = stream_addr[i];
            end else begin
                mem_read_in = 1'b0;
            end
            tick();
            if (i >= 2) begin
                chk($sformatf("stream%0d_valid", i - 2), 32'(read_valid_out), 32'd1);
                chk($sformatf("stream%0d_data", i - 2), read_data_out, stream_exp[i - 2]);
                $display("load  addr=0x%08h data=0x%08h err=%0b (stream)",
                         stream_addr[i - 2], read_data_out, read_error_out);
            end else begin
                chk($sformatf("stream_pre%0d_valid", i), 32'(read_valid_out), 32'd0);
            end
        end
        tick();
        chk("stream_end_valid", 32'(read_valid_out), 32'd0);
        chk("stream_rdcnt", 32'(rd_count_out), 32'd12);

        // Reset with two loads in flight; requests during reset are ignored.
        mem_read_in      = 1'b1;
        mem_read_addr_in = 32'h10;
        tick();
        mem_read_addr_in = 32'h13;
        tick();
        chk("inflight_rdcnt", 32'(rd_count_out), 32'd14);
        reset             = 1'b1;
        mem_read_addr_in  = 32'h10;
        mem_write_in      = 1'b1;
        mem_write_addr_in = 32'h10;
        mem_write_data_in = 32'hFFFFFFFF;
        mem_write_mask_in = 8'h0F;
        tick();
        reset        = 1'b0;
        mem_read_in  = 1'b0;
        mem_write_in = 1'b0;
        chk_idle("midrst");
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("midrst_novalid%0d", i), 32'(read_valid_out), 32'd0);
        end
        load_chk("retain", 32'h10, 32'h55AD1234, 1'b0);
        chk("retain_rdcnt", 32'(rd_count_out), 32'd1);
        chk("retain_wrcnt", 32'(wr_count_out), 32'd0);

        // Store counter wrap.
        mem_write_addr_in = 32'h00;
        mem_write_mask_in = 8'h0F;
        mem_write_in      = 1'b1;
        for (int i = 0; i < 65535; i++) begin
            mem_write_data_in = 32'(i);
            tick();
        end
        mem_write_in = 1'b0;
        $display("store x65535 addr=0x00000000 wr_count=0x%04h", wr_count_out);
        chk("wrap_ffff", 32'(wr_count_out), 32'h0000FFFF);
        store(32'h00, 32'h0000FFFF, 8'h0F);
        chk("wrap_zero", 32'(wr_count_out), 32'h00000000);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
